// File: rtl/controle_estufa_pkg.sv
// Shared types and constants for the greenhouse sequencer and its hysteresis comparator.
package controle_estufa_pkg;

  localparam int SENSOR_W = 4;
  localparam int CMP_W    = 5;

  localparam logic [SENSOR_W-1:0] PLANTA_INVALIDA = 4'hF;

  typedef enum logic [3:0] {
    OCIOSO,
    CARREGA,
    CAPTURA,
    COMP_T,
    COMP_U,
    COMP_L,
    COMP_P,
    ATUALIZA,
    ESPERA
  } estado_t;

  // Widening by one bit keeps s+HIST and ideal+HIST from wrapping.
  function automatic logic [CMP_W-1:0] estende(input logic [SENSOR_W-1:0] v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/controle_estufa_if.sv
// Bus to the plant-ideals ROM: address/enable out, combinational ideal values back.
interface controle_estufa_if;
  import controle_estufa_pkg::*;

  logic [SENSOR_W-1:0] rom_tipo_planta;
  logic                rom_enable;
  logic [SENSOR_W-1:0] rom_temperatura;
  logic [SENSOR_W-1:0] rom_umidade;
  logic [SENSOR_W-1:0] rom_luminosidade;
  logic [SENSOR_W-1:0] rom_ph;

  modport master (
    output rom_tipo_planta, rom_enable,
    input  rom_temperatura, rom_umidade, rom_luminosidade, rom_ph
  );

  modport slave (
    input  rom_tipo_planta, rom_enable,
    output rom_temperatura, rom_umidade, rom_luminosidade, rom_ph
  );

endinterface

// File: rtl/controle_estufa_comparador_histerese.sv
// Next value of a "below-ideal" actuator: on when well below ideal, off at/above ideal, else hold.
module comparador_histerese
  import controle_estufa_pkg::*;
#(
  parameter int HIST = 1
) (
  input  logic [SENSOR_W-1:0] sensor,
  input  logic [SENSOR_W-1:0] ideal,
  input  logic                prev,
  output logic                next
);

  localparam logic [CMP_W-1:0] H = CMP_W'(HIST);

  logic [CMP_W-1:0] s;
  logic [CMP_W-1:0] i;

  assign s = estende(sensor);
  assign i = estende(ideal);

  always_comb begin
    next = prev;
    if (s + H < i)
      next = 1'b1;
    else if (s >= i)
      next = 1'b0;
  end

endmodule

// File: rtl/controle_estufa.sv
// Greenhouse sequencer: loads plant ideals from the ROM, then evaluates one quantity per cycle
// and commits all actuator decisions together every evaluation round.
//
// state    | meaning
// OCIOSO   | idle, waiting for iniciar
// CARREGA  | plant code latched, ROM addressed
// CAPTURA  | latch ROM ideals, reject invalid plant
// COMP_T   | stage heater/cooler decision
// COMP_U   | stage irrigation decision
// COMP_L   | stage lamp decision
// COMP_P   | stage pH alert
// ATUALIZA | commit staged decisions, pulse pronto
// ESPERA   | wait PERIODO cycles before next round
module controle_estufa
  import controle_estufa_pkg::*;
#(
  parameter int PERIODO = 100,
  parameter int HIST    = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                iniciar,
  input  logic                parar,
  input  logic [SENSOR_W-1:0] planta_sel,
  input  logic [SENSOR_W-1:0] sensor_temp,
  input  logic [SENSOR_W-1:0] sensor_umid,
  input  logic [SENSOR_W-1:0] sensor_lum,
  input  logic [SENSOR_W-1:0] sensor_ph,
  controle_estufa_if.master   rom,
  output logic                aquecedor,
  output logic                resfriador,
  output logic                irrigador,
  output logic                lampada,
  output logic                alerta_ph,
  output logic                ocupado,
  output logic                pronto,
  output logic                erro_planta
);

  localparam int              CW    = $clog2(PERIODO + 1);
  localparam logic [CW-1:0]   CARGA = CW'(PERIODO - 1);
  localparam logic [CMP_W-1:0] H    = CMP_W'(HIST);

  estado_t estado, estado_prox;

  logic [SENSOR_W-1:0] tipo;
  logic [SENSOR_W-1:0] ideal_t, ideal_u, ideal_l, ideal_p;
  logic [CW-1:0]       contador;
  logic                st_aq, st_rf, st_ir, st_lp, st_ph;

  logic                abortar;
  logic                aceita;
  logic [SENSOR_W-1:0] cmp_sensor, cmp_ideal;
  logic                cmp_prev, cmp_next;
  logic                rf_next, ph_next;
  logic [CMP_W-1:0]    t5, it5, p5, ip5;

  assign abortar = parar && (estado != OCIOSO);
  assign aceita  = (estado == OCIOSO) && iniciar && !parar;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      estado <= OCIOSO;
    else
      estado <= estado_prox;
  end

  always_comb begin
    estado_prox = estado;
    case (estado)
      OCIOSO:   if (aceita) estado_prox = CARREGA;
      CARREGA:  estado_prox = CAPTURA;
      CAPTURA:  estado_prox = (tipo == PLANTA_INVALIDA) ? OCIOSO : COMP_T;
      COMP_T:   estado_prox = COMP_U;
      COMP_U:   estado_prox = COMP_L;
      COMP_L:   estado_prox = COMP_P;
      COMP_P:   estado_prox = ATUALIZA;
      ATUALIZA: estado_prox = ESPERA;
      ESPERA:   if (contador == '0) estado_prox = COMP_T;
      default:  estado_prox = OCIOSO;
    endcase
    if (abortar)
      estado_prox = OCIOSO;
  end

  // One comparator serves temperature, humidity and light in their own cycles.
  always_comb begin
    cmp_sensor = sensor_temp;
    cmp_ideal  = ideal_t;
    cmp_prev   = aquecedor;
    case (estado)
      COMP_U: begin
        cmp_sensor = sensor_umid;
        cmp_ideal  = ideal_u;
        cmp_prev   = irrigador;
      end
      COMP_L: begin
        cmp_sensor = sensor_lum;
        cmp_ideal  = ideal_l;
        cmp_prev   = lampada;
      end
      default: ;
    endcase
  end

  comparador_histerese #(.HIST(HIST)) u_cmp (
    .sensor (cmp_sensor),
    .ideal  (cmp_ideal),
    .prev   (cmp_prev),
    .next   (cmp_next)
  );

  assign t5  = estende(sensor_temp);
  assign it5 = estende(ideal_t);
  assign p5  = estende(sensor_ph);
  assign ip5 = estende(ideal_p);

  always_comb begin
    rf_next = resfriador;
    if (t5 > it5 + H)
      rf_next = 1'b1;
    else if (t5 <= it5)
      rf_next = 1'b0;
  end

  assign ph_next = (p5 + H < ip5) || (p5 > ip5 + H);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tipo        <= '0;
      ideal_t     <= '0;
      ideal_u     <= '0;
      ideal_l     <= '0;
      ideal_p     <= '0;
      contador    <= '0;
      st_aq       <= 1'b0;
      st_rf       <= 1'b0;
      st_ir       <= 1'b0;
      st_lp       <= 1'b0;
      st_ph       <= 1'b0;
      aquecedor   <= 1'b0;
      resfriador  <= 1'b0;
      irrigador   <= 1'b0;
      lampada     <= 1'b0;
      alerta_ph   <= 1'b0;
      pronto      <= 1'b0;
      erro_planta <= 1'b0;
    end else begin
      pronto <= 1'b0;
      if (abortar) begin
        contador   <= '0;
        st_aq      <= 1'b0;
        st_rf      <= 1'b0;
        st_ir      <= 1'b0;
        st_lp      <= 1'b0;
        st_ph      <= 1'b0;
        aquecedor  <= 1'b0;
        resfriador <= 1'b0;
        irrigador  <= 1'b0;
        lampada    <= 1'b0;
        alerta_ph  <= 1'b0;
      end else begin
        case (estado)
          OCIOSO: if (aceita) begin
            tipo        <= planta_sel;
            erro_planta <= 1'b0;
          end
          CAPTURA: begin
            ideal_t <= rom.rom_temperatura;
            ideal_u <= rom.rom_umidade;
            ideal_l <= rom.rom_luminosidade;
            ideal_p <= rom.rom_ph;
            if (tipo == PLANTA_INVALIDA)
              erro_planta <= 1'b1;
          end
          COMP_T: begin
            st_aq <= cmp_next;
            st_rf <= rf_next;
          end
          COMP_U: st_ir <= cmp_next;
          COMP_L: st_lp <= cmp_next;
          COMP_P: st_ph <= ph_next;
          ATUALIZA: begin
            aquecedor  <= st_aq;
            resfriador <= st_rf;
            irrigador  <= st_ir;
            lampada    <= st_lp;
            alerta_ph  <= st_ph;
            pronto     <= 1'b1;
            contador   <= CARGA;
          end
          ESPERA: if (contador != '0) contador <= contador - 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign rom.rom_tipo_planta = tipo;
  assign rom.rom_enable      = (estado == CARREGA) || (estado == CAPTURA);
  assign ocupado             = (estado != OCIOSO);

endmodule
